// File: rtl/rom_boot_sequencer.sv
// -----------------------------------------------------------------------------
// rom_boot_sequencer
//
// Boot-time copy engine. After a Start request it walks FlashROM addresses
// 0..COPY_LEN-1 and writes each word into the core's instruction memory
// through a valid/ready write port. The core is held stopped for the whole
// copy and is released (CoreRunEnable) only once the final word has been
// accepted by the instruction memory.
//
// Ports
//   clk               system clock, all state changes on the rising edge
//   async_rst_n       asynchronous active-low reset
//   Start             copy request, honoured only in IDLE or DONE
//   RomAddress        address to the combinational FlashROM
//   RomValue          FlashROM data for RomAddress
//   IMemWriteValid    instruction-memory write request
//   IMemWriteReady    instruction memory accepts the write this cycle
//   IMemWriteAddress  write address (same as the ROM address of the word)
//   IMemWriteData     write data
//   Busy              copy in progress (READ or WRITE)
//   Done              copy complete
//   CoreRunEnable     core may fetch/execute (only while Done)
// -----------------------------------------------------------------------------
module rom_boot_sequencer #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int COPY_LEN = 1024
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              Start,
    output logic [ADDR_W-1:0] RomAddress,
    input  logic [DATA_W-1:0] RomValue,
    output logic              IMemWriteValid,
    input  logic              IMemWriteReady,
    output logic [ADDR_W-1:0] IMemWriteAddress,
    output logic [DATA_W-1:0] IMemWriteData,
    output logic              Busy,
    output logic              Done,
    output logic              CoreRunEnable
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Final address of the copy. With COPY_LEN = 2**ADDR_W this is all-ones,
    // so the counter stops on the compare and never has to wrap.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COPY_LEN - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic              run_q;
    logic              handshake;

    assign cnt_d     = cnt_q + ADDR_W'(1);
    // valid_q is only ever set in WRITE, so Ready outside WRITE is inert.
    assign handshake = valid_q & IMemWriteReady;

    // Single FSM process; every output flag is a register updated together
    // with the state so outputs are glitch-free and aligned to the state.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_q <= ST_READ;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                ST_READ: begin
                    // ROM is combinational: the word for cnt_q is present now.
                    // It is captured only here so stalls in WRITE hold it.
                    data_q  <= RomValue;
                    state_q <= ST_WRITE;
                    valid_q <= 1'b1;
                end

                ST_WRITE: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                        if (cnt_q == LAST_ADDR) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            run_q   <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                            cnt_q   <= cnt_d;
                        end
                    end
                end

                ST_DONE: begin
                    // Re-boot: the core is stopped on the same edge the
                    // copy restarts.
                    if (Start) begin
                        state_q <= ST_READ;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        run_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    // The counter drives the ROM in every state so its address is never
    // left floating; the write address is the same counter value.
    assign RomAddress       = cnt_q;
    assign IMemWriteAddress = cnt_q;
    assign IMemWriteData    = data_q;
    assign IMemWriteValid   = valid_q;
    assign Busy             = busy_q;
    assign Done             = done_q;
    assign CoreRunEnable    = run_q;

endmodule

// File: tb/tb_rom_boot_sequencer.sv
module tb_rom_boot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, ready_a, start_b, ready_b;
    logic corrupt;

    logic [9:0]  rom_addr_a, waddr_a, rom_addr_b, waddr_b;
    logic [15:0] rom_val_a, wdata_a, rom_val_b, wdata_b;
    logic        valid_a, busy_a, done_a, run_a;
    logic        valid_b, busy_b, done_b, run_b;

    logic [15:0] rom [0:1023];

    // corrupt lets a test change the ROM word under a stalled write to prove
    // the sequencer does not re-sample the ROM outside READ.
    assign rom_val_a = corrupt ? ~rom[rom_addr_a] : rom[rom_addr_a];
    assign rom_val_b = rom[rom_addr_b];

    rom_boot_sequencer #(.ADDR_W(10), .DATA_W(16), .COPY_LEN(11)) dut_a (
        .clk(clk), .async_rst_n(rst_n), .Start(start_a),
        .RomAddress(rom_addr_a), .RomValue(rom_val_a),
        .IMemWriteValid(valid_a), .IMemWriteReady(ready_a),
        .IMemWriteAddress(waddr_a), .IMemWriteData(wdata_a),
        .Busy(busy_a), .Done(done_a), .CoreRunEnable(run_a)
    );

    rom_boot_sequencer #(.ADDR_W(10), .DATA_W(16), .COPY_LEN(1024)) dut_b (
        .clk(clk), .async_rst_n(rst_n), .Start(start_b),
        .RomAddress(rom_addr_b), .RomValue(rom_val_b),
        .IMemWriteValid(valid_b), .IMemWriteReady(ready_b),
        .IMemWriteAddress(waddr_b), .IMemWriteData(wdata_b),
        .Busy(busy_b), .Done(done_b), .CoreRunEnable(run_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Accepted writes, observed at the rising edge where Valid & Ready.
    logic [9:0]  hs_addr_a[$];
    logic [15:0] hs_data_a[$];
    logic [9:0]  hs_addr_b[$];
    logic [15:0] hs_data_b[$];
    always @(posedge clk) begin
        if (valid_a && ready_a) begin
            hs_addr_a.push_back(waddr_a);
            hs_data_a.push_back(wdata_a);
        end
        if (valid_b && ready_b) begin
            hs_addr_b.push_back(waddr_b);
            hs_data_b.push_back(wdata_b);
        end
    end

    // Pulse Start on dut_a; returns the cycle stamp of the sampling edge.
    task automatic begin_a(output int t0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        t0 = cyc;
    endtask

    // Wait for Done on dut_a; latency counted in edges from the Start edge.
    task automatic finish_a(input int t0, output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        for (int i = 0; i < 400; i++) begin
            if (done_a) begin
                lat = cyc - t0;
                break;
            end
            if (busy_a) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_write_a(input logic [9:0] addr);
        bit found = 0;
        for (int i = 0; i < 400; i++) begin
            if (valid_a && waddr_a == addr) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_write_%0h: write to address %0h never seen", addr, addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 0; start_b = 0; ready_a = 0; ready_b = 0; corrupt = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rom_addr_a, valid_a, waddr_a, wdata_a, busy_a, done_a, run_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs %0h required 0",
                     {rom_addr_a, valid_a, waddr_a, wdata_a, busy_a, done_a, run_a});
        end
        checks++;
        if ({rom_addr_b, valid_b, waddr_b, wdata_b, busy_b, done_b, run_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs %0h required 0",
                     {rom_addr_b, valid_b, waddr_b, wdata_b, busy_b, done_b, run_b});
        end
        rst_n = 1'b1;
        // Ready with no copy running must do nothing.
        ready_a = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_a, busy_a, done_a, run_a} !== 4'b0000 || hs_addr_a.size() != 0) begin
            errors++;
            $display("FAIL idle_ready: valid/busy/done/run=%b writes=%0d required 0000 and 0",
                     {valid_a, busy_a, done_a, run_a}, hs_addr_a.size());
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_copy();
        int t0, lat, busy_n;
        hs_addr_a.delete(); hs_data_a.delete();
        ready_a = 1'b1;
        begin_a(t0);
        finish_a(t0, lat, busy_n);
        checks++;
        if (lat !== 22) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required 22", lat);
        end
        checks++;
        if (busy_n !== 22) begin
            errors++;
            $display("FAIL basic_busy: Busy high %0d cycles required 22", busy_n);
        end
        checks++;
        if (run_a !== 1'b1 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_outputs: run=%b valid=%b required run=1 valid=0", run_a, valid_a);
        end
        checks++;
        if (hs_addr_a.size() != 11) begin
            errors++;
            $display("FAIL basic_count: %0d writes required 11", hs_addr_a.size());
        end
        for (int i = 0; i < hs_addr_a.size() && i < 11; i++) begin
            $display("write %0h <= %04h", hs_addr_a[i], hs_data_a[i]);
            checks++;
            if (hs_addr_a[i] !== 10'(i) || hs_data_a[i] !== rom[i]) begin
                errors++;
                $display("FAIL basic_write_%0d: got (%0h,%04h) required (%0h,%04h)",
                         i, hs_addr_a[i], hs_data_a[i], i, rom[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t0, lat, busy_n;
        hs_addr_a.delete(); hs_data_a.delete();
        ready_a = 1'b1;
        begin_a(t0);
        wait_write_a(10'h3);
        ready_a = 1'b0;
        corrupt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (valid_a !== 1'b1 || waddr_a !== 10'h3 || wdata_a !== 16'hE380) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b addr=%0h data=%04h required 1,3,E380",
                         k, valid_a, waddr_a, wdata_a);
            end
        end
        corrupt = 1'b0;
        ready_a = 1'b1;
        finish_a(t0, lat, busy_n);
        checks++;
        if (lat !== 27) begin
            errors++;
            $display("FAIL stall_latency: got %0d cycles required 27", lat);
        end
        checks++;
        if (hs_addr_a.size() != 11) begin
            errors++;
            $display("FAIL stall_count: %0d writes required 11", hs_addr_a.size());
        end
        for (int i = 0; i < hs_addr_a.size() && i < 11; i++) begin
            checks++;
            if (hs_addr_a[i] !== 10'(i) || hs_data_a[i] !== rom[i]) begin
                errors++;
                $display("FAIL stall_write_%0d: got (%0h,%04h) required (%0h,%04h)",
                         i, hs_addr_a[i], hs_data_a[i], i, rom[i]);
            end
        end
        $display("test_backpressure: %0d writes, latency %0d", hs_addr_a.size(), lat);
    endtask

    task automatic test_start_ignored();
        int t0, lat, busy_n;
        hs_addr_a.delete(); hs_data_a.delete();
        begin_a(t0);
        wait_write_a(10'h5);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        finish_a(t0, lat, busy_n);
        checks++;
        if (lat !== 22 || hs_addr_a.size() != 11) begin
            errors++;
            $display("FAIL start_ignored: latency %0d writes %0d required 22 and 11",
                     lat, hs_addr_a.size());
        end
        checks++;
        if (hs_addr_a.size() != 0 && hs_addr_a[hs_addr_a.size()-1] !== 10'hA) begin
            errors++;
            $display("FAIL start_ignored_last: last address %0h required A",
                     hs_addr_a[hs_addr_a.size()-1]);
        end
        $display("test_start_ignored: %0d writes, latency %0d", hs_addr_a.size(), lat);
    endtask

    task automatic test_reset_midcopy();
        int t0, lat, busy_n;
        begin_a(t0);
        wait_write_a(10'h6);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_addr_a, valid_a, waddr_a, wdata_a, busy_a, done_a, run_a} !== '0) begin
            errors++;
            $display("FAIL midcopy_reset: outputs %0h required 0",
                     {rom_addr_a, valid_a, waddr_a, wdata_a, busy_a, done_a, run_a});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hs_addr_a.delete(); hs_data_a.delete();
        @(negedge clk);
        begin_a(t0);
        finish_a(t0, lat, busy_n);
        checks++;
        if (lat !== 22 || hs_addr_a.size() != 11) begin
            errors++;
            $display("FAIL midcopy_restart: latency %0d writes %0d required 22 and 11",
                     lat, hs_addr_a.size());
        end
        checks++;
        if (hs_addr_a.size() != 0 && (hs_addr_a[0] !== 10'h0 || hs_data_a[0] !== 16'hD188)) begin
            errors++;
            $display("FAIL midcopy_first: got (%0h,%04h) required (0,D188)", hs_addr_a[0], hs_data_a[0]);
        end
        $display("test_reset_midcopy: %0d writes after restart", hs_addr_a.size());
    endtask

    task automatic test_reboot();
        int t0, lat, busy_n;
        hs_addr_a.delete(); hs_data_a.delete();
        checks++;
        if (done_a !== 1'b1 || run_a !== 1'b1) begin
            errors++;
            $display("FAIL reboot_pre: done=%b run=%b required 1 1", done_a, run_a);
        end
        begin_a(t0);
        checks++;
        if (run_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL reboot_drop: run=%b done=%b busy=%b required 0 0 1", run_a, done_a, busy_a);
        end
        finish_a(t0, lat, busy_n);
        checks++;
        if (lat !== 22 || hs_addr_a.size() != 11 || run_a !== 1'b1) begin
            errors++;
            $display("FAIL reboot_copy: latency %0d writes %0d run=%b required 22, 11, 1",
                     lat, hs_addr_a.size(), run_a);
        end
        $display("test_reboot: %0d writes, latency %0d", hs_addr_a.size(), lat);
    endtask

    task automatic test_full_random();
        bit prev_stall = 0;
        logic [9:0]  prev_addr = '0;
        logic [15:0] prev_data = '0;
        int stall_err = 0;
        bit finished = 0;
        hs_addr_b.delete(); hs_data_b.delete();
        ready_b = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done_b) begin
                finished = 1;
                break;
            end
            if (prev_stall && (valid_b !== 1'b1 || waddr_b !== prev_addr || wdata_b !== prev_data))
                stall_err++;
            ready_b = 1'($urandom_range(0, 1));
            prev_stall = valid_b && !ready_b;
            prev_addr = waddr_b;
            prev_data = wdata_b;
            @(negedge clk);
        end
        checks++;
        if (!finished || run_b !== 1'b1 || valid_b !== 1'b0) begin
            errors++;
            $display("FAIL full_done: done=%b run=%b valid=%b required 1 1 0", done_b, run_b, valid_b);
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL full_stall_stable: %0d unstable stall cycles required 0", stall_err);
        end
        checks++;
        if (hs_addr_b.size() != 1024) begin
            errors++;
            $display("FAIL full_count: %0d writes required 1024", hs_addr_b.size());
        end
        for (int i = 0; i < hs_addr_b.size() && i < 1024; i++) begin
            checks++;
            if (hs_addr_b[i] !== 10'(i) || hs_data_b[i] !== rom[i]) begin
                errors++;
                $display("FAIL full_write_%0d: got (%0h,%04h) required (%0h,%04h)",
                         i, hs_addr_b[i], hs_data_b[i], i, rom[i]);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (hs_addr_b.size() != 1024 || rom_addr_b !== 10'h3FF) begin
            errors++;
            $display("FAIL full_no_wrap: writes %0d addr %0h required 1024 and 3FF",
                     hs_addr_b.size(), rom_addr_b);
        end
        $display("test_full_random: %0d writes", hs_addr_b.size());
    endtask

    initial begin
        logic [15:0] image [0:10];
        image = '{16'hD188, 16'hC220, 16'hC300, 16'hE380, 16'h3251, 16'h0111,
                  16'h0111, 16'h3351, 16'h3411, 16'h0074, 16'hB3FD};
        for (int i = 0; i < 1024; i++) rom[i] = (i < 11) ? image[i] : 16'h0000;

        test_reset();
        test_basic_copy();
        test_backpressure();
        test_start_ignored();
        test_reset_midcopy();
        test_reboot();
        test_full_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_boot_sequencer.md
Name: rom_boot_sequencer

Overview:
- Boot-time controller for the 1024x16 combinational instruction FlashROM.
- After a start request, walks ROM addresses 0..COPY_LEN-1 and copies each word into the core's instruction memory through a valid/ready write port.
- Holds the core in a not-running state during the copy; asserts the run enable once the last word is accepted.
- Sits between the FlashROM, the instruction-memory write port and the core's run/reset control.

Parameters:
- ADDR_W, 10, ROM/instruction-memory word address width.
- DATA_W, 16, instruction word width.
- COPY_LEN, 1024, number of words copied, 1..2^ADDR_W; last address copied is COPY_LEN-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- async_rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  level/pulse request to begin a copy; sampled only in IDLE or DONE.
- RomAddress  output  ADDR_W  address driven to the FlashROM.
- RomValue  input  DATA_W  combinational ROM data for RomAddress.
- IMemWriteValid  output  1  write request to instruction memory.
- IMemWriteReady  input  1  instruction memory accepts the write this cycle.
- IMemWriteAddress  output  ADDR_W  write address; equals the ROM address of the word.
- IMemWriteData  output  DATA_W  write data.
- Busy  output  1  high in READ and WRITE.
- Done  output  1  high in DONE.
- CoreRunEnable  output  1  core may fetch/execute; high only in DONE.

Behaviour:
- States: IDLE, READ, WRITE, DONE; encoding is free.
- Reset (async assert, released synchronously to clk by the top level):
  - state=IDLE; address counter=0; data register=0.
  - All outputs 0: RomAddress=0, IMemWriteValid=0, IMemWriteAddress=0, IMemWriteData=0, Busy=0, Done=0, CoreRunEnable=0.
- IDLE: Start=1 -> READ, counter=0. Otherwise stay in IDLE.
- READ (1 cycle):
  - RomAddress=counter.
  - Data register <= RomValue.
  - Unconditional -> WRITE.
- WRITE:
  - IMemWriteValid=1; IMemWriteAddress=counter; IMemWriteData=data register.
  - Address and data stay stable until the handshake (Valid & Ready at a rising edge).
  - On handshake: if counter==COPY_LEN-1 -> DONE; else counter+1 -> READ.
  - No handshake: stay in WRITE.
- DONE:
  - Done=1, CoreRunEnable=1, IMemWriteValid=0.
  - Start=1 -> READ with counter=0; CoreRunEnable drops in the same cycle the state leaves DONE (re-boot).
- RomAddress equals the counter in every state; the ROM is never left floating.
- Start is ignored in READ and WRITE. No queuing; no abort.
- Throughput: 2 cycles per word when Ready=1 continuously.
  - Start sampled at edge E0 -> first write handshake at E2 -> DONE entered at edge E(2*COPY_LEN).
- Counter width is ADDR_W. With COPY_LEN=2^ADDR_W the final compare is against all-ones; the counter never wraps past it.
- Reset mid-copy: immediate return to the reset values; a partially written memory is not cleaned up. A later Start restarts the copy from address 0.
- Ready asserted outside WRITE has no effect.
- Data is captured from ROM in READ only. The data register does not track RomValue during WRITE stalls.

Test Plan:
- COPY_LEN=11, Ready tied 1, Start pulse:
  - Writes (0,D188),(1,C220),(2,C300),(3,E380),(4,3251),(5,0111),(6,0111),(7,3351),(8,3411),(9,0074),(A,B3FD).
  - Done and CoreRunEnable rise 22 cycles after Start is sampled; Busy is high for exactly 22 cycles.
- Backpressure: Ready low for 5 cycles on word 3 -> Valid stays high and Addr=3/Data=E380 stay stable through the stall; the copy completes with 5 extra cycles and no duplicate or skipped address.
- Start re-asserted during WRITE of word 5 -> no effect; the sequence continues to address A and DONE.
- async_rst_n low during word 6, then released, then Start -> all outputs 0 during reset; the copy restarts at address 0; the final write count is 11.
- In DONE, Start pulse -> CoreRunEnable=0 the next cycle; a full recopy runs; DONE is reasserted.
- COPY_LEN=1024, Ready random 50% -> 1024 writes, addresses 0..3FF in order; addresses 00B..3FF carry 0000; no counter wrap; DONE reached.
